// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment constants, capture FSM states and anode helpers
// Patterns are active-low, bit6 = segment a ... bit0 = segment g.
package sseg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [1:0] DIG_0 = 2'd0;
   localparam logic [1:0] DIG_1 = 2'd1;
   localparam logic [1:0] DIG_2 = 2'd2;
   localparam logic [1:0] DIG_3 = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HOLD = 2'd2
   } cap_state_e;

   // Argument is the active-high anode vector (~a_s).
   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = DIG_0;
      if (v[1]) idx = DIG_1;
      if (v[2]) idx = DIG_2;
      if (v[3]) idx = DIG_3;
      return idx;
   endfunction

endpackage

// File: rtl/sseg_decode.sv
// rtl/sseg_decode.sv - combinational segment-pattern to BCD nibble decoder
// Hex letters decode as legal only when SSEG_CAPTURE_HEX_EN is defined.
module sseg_decode
   import sseg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output logic       illegal_o
);

   always_comb begin
      nibble_o  = 4'hF;
      illegal_o = 1'b0;
      case (seg_i)
         SEG_0:   nibble_o = 4'h0;
         SEG_1:   nibble_o = 4'h1;
         SEG_2:   nibble_o = 4'h2;
         SEG_3:   nibble_o = 4'h3;
         SEG_4:   nibble_o = 4'h4;
         SEG_5:   nibble_o = 4'h5;
         SEG_6:   nibble_o = 4'h6;
         SEG_7:   nibble_o = 4'h7;
         SEG_8:   nibble_o = 4'h8;
         SEG_9:   nibble_o = 4'h9;
`ifdef SSEG_CAPTURE_HEX_EN
         SEG_A:   nibble_o = 4'hA;
         SEG_B:   nibble_o = 4'hB;
         SEG_C:   nibble_o = 4'hC;
         SEG_D:   nibble_o = 4'hD;
         SEG_E:   nibble_o = 4'hE;
         SEG_F:   nibble_o = 4'hF;
`else
`endif
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - seven-segment bus monitor: qualifies lit digits, rebuilds 16-bit BCD frames
// Optional hex-letter decode is controlled by SSEG_CAPTURE_HEX_EN inside sseg_decode.
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int STABLE_CYC  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TO_W        = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  sseg_a_i,
   input  logic [6:0]  sseg_c_i,
   output logic [15:0] bcd_o,
   output logic        frame_valid_o,
   output logic        digit_err_o,
   output logic        stale_o
);

   localparam int          AW         = 4 * SYNC_STAGES;
   localparam int          CW         = 7 * SYNC_STAGES;
   localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYC);
   localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

   logic [AW-1:0]     a_sync_q, a_sync_d;
   logic [CW-1:0]     c_sync_q, c_sync_d;
   cap_state_e        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [6:0]        pat_q, pat_d;
   logic [7:0]        stable_cnt_q, stable_cnt_d;
   logic [15:0]       shadow_q, shadow_d;
   logic [3:0]        seen_mask_q, seen_mask_d;
   logic              err_acc_q, err_acc_d;
   logic [TO_W-1:0]   timeout_cnt_q, timeout_cnt_d;
   logic [15:0]       bcd_q, bcd_d;
   logic              frame_valid_q, frame_valid_d;
   logic              digit_err_q, digit_err_d;
   logic              stale_q, stale_d;

   logic [3:0] a_s;
   logic [6:0] c_s;
   logic       active;
   logic [1:0] idx_s;
   logic       same_pair;
   logic       start_pair;
   logic       capture;
   logic       complete;
   logic [3:0] dec_nibble;
   logic       dec_illegal;

   assign a_s    = a_sync_q[AW-1 -: 4];
   assign c_s    = c_sync_q[CW-1 -: 7];
   assign active = onehot4(~a_s) && (c_s != SEG_BLANK);
   assign idx_s  = onehot_idx(~a_s);

   sseg_decode u_decode (
      .seg_i     (c_s),
      .nibble_o  (dec_nibble),
      .illegal_o (dec_illegal)
   );

   always_comb begin
      if (SYNC_STAGES > 1) begin
         a_sync_d = {a_sync_q[AW-5:0], sseg_a_i};
         c_sync_d = {c_sync_q[CW-8:0], sseg_c_i};
      end else begin
         a_sync_d = sseg_a_i;
         c_sync_d = sseg_c_i;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      pat_d        = pat_q;
      stable_cnt_d = stable_cnt_q;
      shadow_d     = shadow_q;
      start_pair   = 1'b0;
      capture      = 1'b0;
      same_pair    = active && (idx_s == idx_q) && (c_s == pat_q);
      complete     = (seen_mask_q == 4'b1111);

      case (state_q)
         IDLE: begin
            if (active) start_pair = 1'b1;
         end
         QUAL: begin
            if (!active) begin
               state_d = IDLE;
            end else if (same_pair) begin
               stable_cnt_d = stable_cnt_q + 8'd1;
               if (stable_cnt_d == STABLE_MAX) begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end else begin
               start_pair = 1'b1;
            end
         end
         HOLD: begin
            if (!same_pair) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A fresh pair with STABLE_CYC of 1 is already qualified on its first cycle.
      if (start_pair) begin
         idx_d        = idx_s;
         pat_d        = c_s;
         stable_cnt_d = 8'd1;
         if (STABLE_MAX == 8'd1) begin
            capture = 1'b1;
            state_d = HOLD;
         end else begin
            state_d = QUAL;
         end
      end

      if (capture) shadow_d[{idx_s, 2'b00} +: 4] = dec_nibble;

      seen_mask_d = (complete ? 4'b0000 : seen_mask_q) | (capture ? (4'b0001 << idx_s) : 4'b0000);
      err_acc_d   = (complete ? 1'b0 : err_acc_q) | (capture & dec_illegal);

      if (complete)
         timeout_cnt_d = '0;
      else if (timeout_cnt_q == TO_MAX)
         timeout_cnt_d = timeout_cnt_q;
      else
         timeout_cnt_d = timeout_cnt_q + 1'b1;

      bcd_d         = complete ? shadow_q : bcd_q;
      digit_err_d   = complete ? err_acc_q : digit_err_q;
      frame_valid_d = complete;
      stale_d       = (timeout_cnt_d == TO_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync_q      <= '1;
         c_sync_q      <= '1;
         state_q       <= IDLE;
         idx_q         <= DIG_0;
         pat_q         <= SEG_BLANK;
         stable_cnt_q  <= 8'd0;
         shadow_q      <= 16'h0000;
         seen_mask_q   <= 4'b0000;
         err_acc_q     <= 1'b0;
         timeout_cnt_q <= '0;
         bcd_q         <= 16'h0000;
         frame_valid_q <= 1'b0;
         digit_err_q   <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         a_sync_q      <= a_sync_d;
         c_sync_q      <= c_sync_d;
         state_q       <= state_d;
         idx_q         <= idx_d;
         pat_q         <= pat_d;
         stable_cnt_q  <= stable_cnt_d;
         shadow_q      <= shadow_d;
         seen_mask_q   <= seen_mask_d;
         err_acc_q     <= err_acc_d;
         timeout_cnt_q <= timeout_cnt_d;
         bcd_q         <= bcd_d;
         frame_valid_q <= frame_valid_d;
         digit_err_q   <= digit_err_d;
         stale_q       <= stale_d;
      end
   end

   assign bcd_o         = bcd_q;
   assign frame_valid_o = frame_valid_q;
   assign digit_err_o   = digit_err_q;
   assign stale_o       = stale_q;

endmodule

// File: tb/tb_sseg_capture.sv
// tb/tb_sseg_capture.sv - directed self-checking bench for sseg_capture
// Drives a multiplexed display bus and checks reassembled frames, errors and staleness.
module tb_sseg_capture;

   logic        clk;
   logic        rst_n;
   logic [3:0]  sseg_a_i;
   logic [6:0]  sseg_c_i;
   logic [15:0] bcd_o;
   logic        frame_valid_o;
   logic        digit_err_o;
   logic        stale_o;

   int checks;
   int fails;
   int fv_cnt;
   logic [15:0] last_bcd;
   logic        last_err;
   logic        last_stale;

   sseg_capture dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sseg_a_i      (sseg_a_i),
      .sseg_c_i      (sseg_c_i),
      .bcd_o         (bcd_o),
      .frame_valid_o (frame_valid_o),
      .digit_err_o   (digit_err_o),
      .stale_o       (stale_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid_o === 1'b1) begin
         fv_cnt     = fv_cnt + 1;
         last_bcd   = bcd_o;
         last_err   = digit_err_o;
         last_stale = stale_o;
      end
   end

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         default: return 7'b1111110;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      sseg_a_i = 4'b1111;
      sseg_c_i = 7'b1111111;
      repeat (n) @(negedge clk);
   endtask

   task automatic light(input int idx, input logic [6:0] pat);
      sseg_a_i = ~(4'b0001 << idx);
      sseg_c_i = pat;
      repeat (64) @(negedge clk);
      idle(192);
   endtask

   task automatic scan(input logic [15:0] v);
      for (int d = 0; d < 4; d++) light(d, seg_of(v[d*4 +: 4]));
   endtask

   initial begin
      int exp_fv;
      checks   = 0;
      fails    = 0;
      fv_cnt   = 0;
      last_bcd = 16'h0;
      last_err = 1'b0;
      last_stale = 1'b0;
      exp_fv   = 0;
      rst_n    = 1'b0;
      sseg_a_i = 4'b1111;
      sseg_c_i = 7'b1111111;
      repeat (3) @(negedge clk);
      check("reset_bcd", bcd_o, 16'h0000);
      check("reset_fv", frame_valid_o, 1'b0);
      check("reset_err", digit_err_o, 1'b0);
      check("reset_stale", stale_o, 1'b0);
      rst_n = 1'b1;
      idle(4);

      // Ideal scans of 1234: one frame per full scan
      for (int s = 0; s < 3; s++) begin
         scan(16'h1234);
         exp_fv++;
         check("scan_fv_cnt", fv_cnt, exp_fv);
      end
      check("scan_bcd", last_bcd, 16'h1234);
      check("scan_err", last_err, 1'b0);
      check("scan_bcd_held", bcd_o, 16'h1234);

      // Glitch: digit 2 flashes an 8 for STABLE_CYC-1 cycles before a steady 2
      light(0, seg_of(4'h0));
      light(1, seg_of(4'h1));
      sseg_a_i = 4'b1011;
      sseg_c_i = 7'b0000000;
      repeat (3) @(negedge clk);
      sseg_c_i = 7'b0010010;
      repeat (61) @(negedge clk);
      idle(192);
      light(3, seg_of(4'h3));
      exp_fv++;
      check("glitch_fv_cnt", fv_cnt, exp_fv);
      check("glitch_bcd", last_bcd, 16'h3210);
      check("glitch_err", last_err, 1'b0);

      // Two anodes lit: no capture, so three more digits must not complete a frame
      sseg_a_i = 4'b0011;
      sseg_c_i = seg_of(4'h5);
      repeat (100) @(negedge clk);
      idle(50);
      check("multi_fv_cnt", fv_cnt, exp_fv);
      check("multi_err", digit_err_o, 1'b0);
      check("multi_bcd", bcd_o, 16'h3210);
      light(0, seg_of(4'h9));
      light(1, seg_of(4'h8));
      light(2, seg_of(4'h7));
      check("multi_partial_fv", fv_cnt, exp_fv);
      light(3, seg_of(4'h6));
      exp_fv++;
      check("multi_done_fv", fv_cnt, exp_fv);
      check("multi_done_bcd", last_bcd, 16'h6789);

      // Illegal pattern on digit 0
      light(0, 7'b1111110);
      light(1, seg_of(4'h7));
      light(2, seg_of(4'h8));
      light(3, seg_of(4'h9));
      exp_fv++;
      check("illegal_fv_cnt", fv_cnt, exp_fv);
      check("illegal_bcd", last_bcd, 16'h987F);
      check("illegal_err", last_err, 1'b1);
      check("illegal_err_out", digit_err_o, 1'b1);
      scan(16'h1234);
      exp_fv++;
      check("clean_fv_cnt", fv_cnt, exp_fv);
      check("clean_err", last_err, 1'b0);

      // Reset after digits 3 and 2 captured; partial frame must be discarded
      light(3, seg_of(4'h1));
      light(2, seg_of(4'h2));
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_bcd", bcd_o, 16'h0000);
      check("midrst_err", digit_err_o, 1'b0);
      rst_n = 1'b1;
      idle(4);
      light(0, seg_of(4'h8));
      light(1, seg_of(4'h7));
      check("midrst_no_early", fv_cnt, exp_fv);
      light(2, seg_of(4'h6));
      light(3, seg_of(4'h5));
      exp_fv++;
      check("midrst_fv_cnt", fv_cnt, exp_fv);
      check("midrst_bcd_frame", last_bcd, 16'h5678);
      check("midrst_err_frame", last_err, 1'b0);

      // Idle bus: stale rises roughly 2^TO_W cycles after the last frame
      idle(3600);
      check("stale_early", stale_o, 1'b0);
      idle(400);
      check("stale_set", stale_o, 1'b1);
      check("stale_bcd_held", bcd_o, 16'h5678);
      check("stale_fv_cnt", fv_cnt, exp_fv);

      // Hex letter A on digit 3
      light(0, seg_of(4'h3));
      light(1, seg_of(4'h2));
      light(2, seg_of(4'h1));
      light(3, 7'b0001000);
      exp_fv++;
      check("hex_fv_cnt", fv_cnt, exp_fv);
      check("hex_stale_at_frame", last_stale, 1'b0);
      check("hex_stale_now", stale_o, 1'b0);
`ifdef SSEG_CAPTURE_HEX_EN
      check("hex_bcd", last_bcd, 16'hA123);
      check("hex_err", last_err, 1'b0);
`else
      check("hex_bcd", last_bcd, 16'hF123);
      check("hex_err", last_err, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Receive-side monitor for the time-multiplexed 4-digit seven-segment bus (active-low anodes, active-low cathodes).
- Samples the anode and cathode lines, qualifies each lit digit, and decodes the segment pattern back to a BCD nibble.
- Reassembles a 16-bit BCD frame and flags errors.
- Used as an on-chip loopback checker and as the bench-side reference monitor for the display driver.

Parameters:
- STABLE_CYC, 4: consecutive synchronized cycles a (digit, pattern) pair must hold before it is captured; range 1..255.
- SYNC_STAGES, 2: flop stages on every input bit; range 2..3.
- TO_W, 12: width of the frame timeout counter; a timeout occurs after 2^TO_W cycles without a frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sseg_a_i  input  4  anodes, active-low; bit3 = digit 3 (most significant, bcd[15:12])
- sseg_c_i  input  7  cathodes, active-low; bit6 = segment a ... bit0 = segment g
- bcd_o  output  16  last complete frame; digit3 in [15:12]
- frame_valid_o  output  1  one-cycle pulse when bcd_o updates
- digit_err_o  output  1  set with each frame if any nibble in it decoded illegal
- stale_o  output  1  high while no frame has completed for 2^TO_W cycles

Behaviour:
- Reset is asynchronous and active-low, with one clock, clk. While rst_n is low:
  - bcd_o = 16'h0000, frame_valid_o = 0, digit_err_o = 0, stale_o = 0.
  - Sync flops load 1s (idle bus), the FSM goes to IDLE, and seen_mask, stable_cnt and timeout_cnt clear.
- Inputs pass through SYNC_STAGES flops. All logic below uses the synchronized values a_s and c_s.
- A sample is active when exactly one bit of ~a_s is set and c_s != 7'b1111111. Zero anodes, more than one anode, or all segments off counts as blank.
- Decode table (c_s to nibble):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
  - Any other active pattern is illegal: the nibble is 4'hF and the error flag is set.
- FSM:
  - IDLE: on an active sample, latch digit index and pattern, stable_cnt = 1, go to QUAL.
  - QUAL: if the sample matches the latched pair, stable_cnt increments. When stable_cnt reaches STABLE_CYC, the digit is captured: write the nibble to shadow[idx], set seen_mask[idx], OR the illegal flag into err_acc, go to HOLD. A blank sample goes to IDLE. A different active sample restarts QUAL with the new pair and stable_cnt = 1.
  - HOLD: stay while the sample equals the captured pair. Any change (blank or different pair) goes to IDLE. The same digit cannot be captured twice within one lit period.
- Frame completion: the cycle after seen_mask becomes 4'b1111:
  - bcd_o = shadow, digit_err_o = err_acc, frame_valid_o = 1 for one cycle.
  - seen_mask and err_acc clear.
  - Same-digit recaptures before completion overwrite that shadow nibble; the last capture wins.
- Latency: a pattern stable from synchronized cycle t is captured at t+STABLE_CYC-1. frame_valid_o follows 1 cycle after the final digit's capture.
- Timeout: timeout_cnt increments every cycle and clears on frame completion; it saturates at all-ones.
  - stale_o = 1 while saturated; it drops in the cycle frame_valid_o pulses.
  - bcd_o holds its last value while stale.
- Multiple active anodes never capture and never set digit_err_o.
- Reset mid-frame discards the partial shadow. The first frame after reset needs all four digits freshly captured.

Optional Feature:
- Macro: SSEG_CAPTURE_HEX_EN.
- Defined: these patterns decode as hex and are legal:
  - 0001000=A, 1100000=b, 0110001=C
  - 1000010=d, 0110000=E, 0111000=F
- Undefined: those patterns are illegal (nibble 4'hF, error flag set).
- The decimal table is identical in both builds.

Decomposition:
- Shared package sseg_pkg holds:
  - Segment pattern constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK = 7'b1111111.
  - FSM state typedef (IDLE, QUAL, HOLD).
  - Digit-index constants.
- The display driver's encoder reuses the same constants.
- One sub-module: sseg_decode, a combinational pattern-to-{nibble, illegal} decoder; the SSEG_CAPTURE_HEX_EN switch lives inside it.

Test Plan:
- Drive an ideal multiplexed bus for 16'h1234: each digit lit 64 cycles, blanked 192. Required: frame_valid_o pulses once per full scan, bcd_o = 16'h1234, digit_err_o = 0.
- Glitch: digit 2 shows 7'b0000000 for STABLE_CYC-1 cycles, then a steady 7'b0010010. Required: nibble captured is 2, never 8.
- Anodes 4'b0011 with a valid pattern for 100 cycles. Required: no capture, no frame, digit_err_o unchanged.
- Digit 0 pattern 7'b1111110 with others valid (16'h987x). Required: bcd_o = 16'h987F, digit_err_o = 1. Next clean frame: digit_err_o = 0.
- rst_n low after 2 digits captured, then released with a full scan of 16'h5678. Required: first frame = 16'h5678 with no stale nibbles. Then hold the bus idle 2^TO_W cycles: stale_o rises, bcd_o = 16'h5678 is held.
- With SSEG_CAPTURE_HEX_EN: pattern 7'b0001000 on digit 3 gives bcd_o[15:12] = 4'hA, digit_err_o = 0. Without the macro: 4'hF, digit_err_o = 1.
